ccff_loader: RTL and testbench

Configuration-chain loader for routing tiles such as the unique connection and switch blocks. It accepts bitstream words from the host over a valid/ready stream and serialises them onto a tile's `ccff_head`. It asserts a shift enable for exactly the chain length and optionally verifies the chain contents by comparing `ccff_tail` during a second pass. It sits between the bitstream DMA/host port and the first tile of a configuration-chain segment.

---
 rtl/ccff_pkg.sv | 18 +
 rtl/ccff_piso.sv | 31 +++
 rtl/ccff_loader.sv | 122 ++++++++++++
 tb/tb_ccff_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// rtl/ccff_pkg.sv - shared types and helpers for the configuration-chain loader
//   ccff_state_e : loader FSM states
//   cnt_width()  : bit-counter width able to hold 2*chain_len
package ccff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ccff_state_e;

    // A verify load shifts the chain twice, so the counter must reach 2*chain_len.
    function automatic int cnt_width(input int chain_len);
        return $clog2(2 * chain_len + 1);
    endfunction

endpackage

// File: rtl/ccff_piso.sv
// rtl/ccff_piso.sv - WORD_W parallel-in/serial-out register, MSB first
//   prog_clk, pReset : clock, asynchronous active-low reset
//   load, load_data  : parallel load (has priority over shift)
//   shift            : shift left by one, zero fill
//   msb              : current serial output bit
module ccff_piso #(
    parameter int WORD_W = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              shift,
    output logic              msb
);

    logic [WORD_W-1:0] sr;

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_data;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign msb = sr[WORD_W-1];

endmodule

// File: rtl/ccff_loader.sv
// rtl/ccff_loader.sv - serialises bitstream words onto a configuration chain, optional verify pass
//   prog_clk, pReset        : clock, asynchronous active-low reset
//   start, check, abort     : load request, verify select, synchronous abort
//   s_data, s_valid, s_ready: bitstream word stream
//   ccff_head, ccff_shift_en, ccff_tail : chain serial in, shift enable, serial out
//   busy, done, error, bit_count        : status
module ccff_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 48,
    parameter int CNT_W     = ccff_pkg::cnt_width(CHAIN_LEN)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              check,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  bit_count
);

    import ccff_pkg::*;

    localparam int WB_W = $clog2(WORD_W + 1);

    ccff_state_e      state, state_n;
    logic             check_q;
    logic [CNT_W-1:0] target;
    logic [WB_W-1:0]  word_bits;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept, do_shift, start_acc, verify;

    assign cnt_inc   = bit_count + CNT_W'(1);
    assign start_acc = start && !abort && (state == ST_IDLE || state == ST_DONE);
    // Second pass: the tail now presents the bits written during the first pass.
    assign verify    = check_q && (bit_count >= CNT_W'(CHAIN_LEN));

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        do_shift = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_n = ST_FETCH;
            end
            ST_FETCH: begin
                if (s_valid && s_ready) begin
                    accept  = 1'b1;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                do_shift = 1'b1;
                // Reaching the target ends the word early; leftover bits are dropped.
                if (cnt_inc == target) begin
                    state_n = ST_DONE;
                end else if (word_bits == WB_W'(WORD_W - 1)) begin
                    state_n = ST_FETCH;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (abort) state_n = ST_IDLE;
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state         <= ST_IDLE;
            s_ready       <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            bit_count     <= '0;
            check_q       <= 1'b0;
            target        <= CNT_W'(CHAIN_LEN);
            word_bits     <= '0;
        end else begin
            state <= state_n;
            // Outputs are decoded from the next state so they are flop outputs.
            s_ready       <= (state_n == ST_FETCH);
            ccff_shift_en <= (state_n == ST_SHIFT);
            busy          <= (state_n == ST_FETCH) || (state_n == ST_SHIFT);
            done          <= (state_n == ST_DONE);

            if (start_acc) begin
                bit_count <= '0;
                error     <= 1'b0;
                check_q   <= check;
                target    <= check ? CNT_W'(2 * CHAIN_LEN) : CNT_W'(CHAIN_LEN);
            end else if (do_shift) begin
                bit_count <= cnt_inc;
                if (verify && (ccff_tail != ccff_head)) error <= 1'b1;
            end

            if (accept) begin
                word_bits <= '0;
            end else if (do_shift) begin
                word_bits <= word_bits + WB_W'(1);
            end
        end
    end

    ccff_piso #(
        .WORD_W(WORD_W)
    ) u_piso (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .load     (accept),
        .load_data(s_data),
        .shift    (do_shift),
        .msb      (ccff_head)
    );

endmodule

// File: tb/tb_ccff_loader.sv
// tb/tb_ccff_loader.sv - self-checking bench for ccff_loader
module tb_ccff_loader;

    localparam int W   = 8;
    localparam int L   = 48;
    localparam int L2  = 13;
    localparam int CW  = ccff_pkg::cnt_width(L);
    localparam int CW2 = ccff_pkg::cnt_width(L2);
    localparam int NW  = (L + W - 1) / W;

    logic          prog_clk = 1'b0;
    logic          pReset   = 1'b0;
    logic          start = 1'b0, check = 1'b0, abort = 1'b0, s_valid = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic          s_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, error;
    logic [CW-1:0] bit_count;

    logic           start2 = 1'b0, check2 = 1'b0, abort2 = 1'b0, valid2 = 1'b0, tail2 = 1'b0;
    logic [W-1:0]   data2 = '0;
    logic           ready2, head2, shift_en2, busy2, done2, error2;
    logic [CW2-1:0] bit_count2;

    int total = 0;
    int bad   = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_loader #(.WORD_W(W), .CHAIN_LEN(L)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .check(check), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .ccff_head(ccff_head),
        .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .busy(busy), .done(done),
        .error(error), .bit_count(bit_count)
    );

    ccff_loader #(.WORD_W(W), .CHAIN_LEN(L2)) dut2 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start2), .check(check2), .abort(abort2),
        .s_data(data2), .s_valid(valid2), .s_ready(ready2), .ccff_head(head2),
        .ccff_shift_en(shift_en2), .ccff_tail(tail2), .busy(busy2), .done(done2),
        .error(error2), .bit_count(bit_count2)
    );

    // External chain model: head enters position 0, tail is the last flop.
    logic [L-1:0] chain   = '0;
    int           n_tot   = 0;
    int           flip_at = -1;
    bit           obs[$];
    bit           obs2[$];
    int           acc2    = 0;

    assign ccff_tail = chain[L-1];

    always @(posedge prog_clk) begin : chain_model
        logic [L-1:0] nxt;
        if (ccff_shift_en) begin
            nxt = {chain[L-2:0], ccff_head};
            // After pass 1, chain position L-1-17 holds bit 17 of that pass.
            if (n_tot + 1 == flip_at) nxt[L-1-17] = ~nxt[L-1-17];
            chain <= nxt;
            n_tot <= n_tot + 1;
            obs.push_back(ccff_head);
        end
    end

    always @(posedge prog_clk) begin : mon2
        if (shift_en2) obs2.push_back(head2);
        if (valid2 && ready2) acc2 <= acc2 + 1;
    end

    logic [W-1:0] wq[$];

    task automatic check_eq(input string tag, input longint obs_v, input longint exp_v);
        total++;
        assert (obs_v === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs_v, exp_v);
        end
    endtask

    // Bit i of the expected head stream: each pass repeats the same words, MSB first.
    function automatic bit exp_bit(input int i);
        int     p;
        logic [W-1:0] w;
        p = i % L;
        w = wq[p / W];
        return w[W-1-(p % W)];
    endfunction

    task automatic run_load(input bit chk, input int stall, input int cut_bit,
                            input bit cut_rst, input bit flip);
        int base, base_tot, k, wi, stall_left, first_err, done_k, npass, mism;
        bit cut;
        base     = obs.size();
        base_tot = n_tot;
        npass    = chk ? 2 : 1;
        flip_at  = flip ? base_tot + L : -1;
        @(negedge prog_clk);
        start = 1'b1;
        check = chk;
        k = 0; wi = 0; stall_left = stall; done_k = -1; first_err = -1; cut = 1'b0;
        while (k < 2000) begin
            @(negedge prog_clk);
            k++;
            start = (k > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            check = 1'($urandom_range(0, 1));
            if (k == 1) check_eq("count_cleared_on_start", bit_count, 0);
            if (error && first_err < 0) first_err = int'(bit_count);
            if (done) begin
                done_k = k;
                break;
            end
            if (cut_bit >= 0 && ccff_shift_en && int'(bit_count) == cut_bit) begin
                cut = 1'b1;
                break;
            end
            if (s_ready) begin
                if (stall_left > 0) begin
                    s_valid = 1'b0;
                    stall_left--;
                end else begin
                    s_valid    = 1'b1;
                    s_data     = wq[wi % NW];
                    wi++;
                    stall_left = stall;
                end
            end else begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = W'($urandom);
            end
        end
        start   = 1'b0;
        s_valid = 1'b0;
        if (cut) begin
            if (!cut_rst) begin
                abort = 1'b1;
                @(negedge prog_clk);
                abort = 1'b0;
                check_eq("abort_shift_en", ccff_shift_en, 0);
                check_eq("abort_done", done, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_ready", s_ready, 0);
            end else begin
                #2 pReset = 1'b0;
                #1 check_eq("async_reset_outputs",
                            {s_ready, ccff_shift_en, ccff_head, busy, done, error, bit_count}, 0);
                @(negedge prog_clk);
                pReset = 1'b1;
            end
            return;
        end
        check_eq("done_seen", done_k >= 0, 1);
        check_eq("done_cycle", done_k, 1 + npass * NW * (stall + 1) + npass * L);
        check_eq("shift_cycles", obs.size() - base, npass * L);
        mism = 0;
        for (int i = 0; i < npass * L && base + i < obs.size(); i++)
            if (obs[base+i] != exp_bit(i)) mism++;
        check_eq("head_stream_mismatches", mism, 0);
        check_eq("bit_count_final", bit_count, npass * L);
        check_eq("error_final", error, flip);
        check_eq("error_first_count", first_err, flip ? L + 17 + 1 : -1);
        check_eq("busy_after_done", busy, 0);
    endtask

    task automatic random_words();
        wq.delete();
        for (int i = 0; i < NW; i++) wq.push_back(W'($urandom));
    endtask

    initial begin
        int k;
        logic [W-1:0] w0, w1;
        bit exp2[$];
        int mism2;

        repeat (2) @(negedge prog_clk);
        check_eq("rst_s_ready", s_ready, 0);
        check_eq("rst_shift_en", ccff_shift_en, 0);
        check_eq("rst_head", ccff_head, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_bit_count", bit_count, 0);
        @(negedge prog_clk);
        pReset = 1'b1;

        wq.delete();
        for (int i = 0; i < NW; i++) wq.push_back(8'hA5);
        run_load(1'b0, 0, -1, 1'b0, 1'b0);

        random_words();
        run_load(1'b1, 0, -1, 1'b0, 1'b0);

        random_words();
        run_load(1'b1, 0, -1, 1'b0, 1'b1);

        random_words();
        run_load(1'b0, 5, -1, 1'b0, 1'b0);

        random_words();
        run_load(1'b0, 0, 20, 1'b0, 1'b0);
        run_load(1'b0, 0, -1, 1'b0, 1'b0);

        random_words();
        run_load(1'b1, 0, 10, 1'b1, 1'b0);
        run_load(1'b1, 2, -1, 1'b0, 1'b0);

        // Short chain: 13 bits from two words, last 3 bits of word 2 unused.
        w0 = W'($urandom);
        w1 = W'($urandom);
        @(negedge prog_clk);
        start2 = 1'b1;
        valid2 = 1'b1;
        data2  = w0;
        k = 0;
        while (k < 200 && !done2) begin
            @(negedge prog_clk);
            k++;
            start2 = 1'b0;
            if (ready2) data2 = (acc2 == 0) ? w0 : w1;
        end
        valid2 = 1'b0;
        check_eq("short_done", done2, 1);
        check_eq("short_words_accepted", acc2, 2);
        check_eq("short_shifts", obs2.size(), L2);
        check_eq("short_bit_count", bit_count2, L2);
        check_eq("short_error_busy", {error2, busy2}, 0);
        for (int i = 0; i < W; i++) exp2.push_back(w0[W-1-i]);
        for (int i = 0; i < L2 - W; i++) exp2.push_back(w1[W-1-i]);
        mism2 = 0;
        for (int i = 0; i < L2 && i < obs2.size(); i++)
            if (obs2[i] != exp2[i]) mism2++;
        check_eq("short_stream_mismatches", mism2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
